// File: rtl/bus_arbiter.sv
// Fixed-priority arbiter for the shared backplane bus: one transaction in flight, registered capture.
// Optional ack timeout is compiled in with `define BUSARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned TMOCNT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      reqI,
  input  logic [36*NREQ-1:0]   addrI,
  input  logic [36*NREQ-1:0]   dataI,
  output logic [NREQ-1:0]      ackO,
  output logic [35:0]          dataO,
  output logic                 busREQO,
  input  logic                 busACKI,
  output logic [35:0]          busADDRO,
  output logic [35:0]          busDATAO,
  input  logic [35:0]          busDATAI,
  output logic [NREQ-1:0]      grantO,
  output logic                 busyO,
  output logic                 tmoO
);

  if (NREQ == 0 || TMOCNT == 0) begin : gParamCheck
    $error("bus_arbiter: NREQ and TMOCNT must be nonzero");
  end

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StWait,
    StRelease
  } stateT;

  stateT stateQ, stateD;

  logic [NREQ-1:0] grantQ;
  logic [35:0]     busAddrQ;
  logic [35:0]     busDataQ;
  logic [35:0]     rdDataQ;
  logic            tmoFlagQ;

  logic [NREQ-1:0] pickOneHot;
  logic [35:0]     pickAddr;
  logic [35:0]     pickData;
  logic            tmoHit;

  // Lowest set bit wins: index 0 has the highest priority.
  assign pickOneHot = reqI & (~reqI + NREQ'(1));

  always_comb begin
    pickAddr = '0;
    pickData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pickOneHot[i]) begin
        pickAddr = addrI[36*i +: 36];
        pickData = dataI[36*i +: 36];
      end
    end
  end

`ifdef BUSARB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TMOCNT + 1) > 8) ? $clog2(TMOCNT + 1) : 8;

  logic [CntW-1:0] tmoCntQ;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmoCntQ <= '0;
    end else if (stateQ == StIdle) begin
      tmoCntQ <= '0;
    end else if (stateQ == StGrant || stateQ == StWait) begin
      tmoCntQ <= tmoCntQ + CntW'(1);
    end
  end

  assign tmoHit = (tmoCntQ == CntW'(TMOCNT));
`else
  assign tmoHit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (|reqI) stateD = StGrant;
      end
      StGrant, StWait: begin
        // A real ack on the same edge as the timeout takes precedence.
        if (busACKI || tmoHit) stateD = StRelease;
        else                   stateD = StWait;
      end
      StRelease: stateD = StIdle;
      default:   stateD = StIdle;
    endcase
  end

  // Transaction datapath: grant, captured address/data and returned read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grantQ   <= '0;
      busAddrQ <= '0;
      busDataQ <= '0;
      rdDataQ  <= '0;
      tmoFlagQ <= 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (|reqI) begin
            grantQ   <= pickOneHot;
            busAddrQ <= pickAddr;
            busDataQ <= pickData;
            tmoFlagQ <= 1'b0;
          end
        end
        StGrant, StWait: begin
          if (busACKI) begin
            rdDataQ  <= busDATAI;
            tmoFlagQ <= 1'b0;
          end else if (tmoHit) begin
            rdDataQ  <= '0;
            tmoFlagQ <= 1'b1;
          end
        end
        StRelease: begin
          grantQ   <= '0;
          tmoFlagQ <= 1'b0;
        end
        default: grantQ <= '0;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    busREQO  = (stateQ == StGrant);
    busyO    = (stateQ != StIdle);
    ackO     = (stateQ == StRelease) ? grantQ : '0;
    tmoO     = (stateQ == StRelease) && tmoFlagQ;
    grantO   = grantQ;
    busADDRO = busAddrQ;
    busDATAO = busDataQ;
    dataO    = rdDataQ;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (NREQ=4, TMOCNT=16).
module tb_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   reqI;
  logic [143:0] addrI;
  logic [143:0] dataI;
  logic [3:0]   ackO;
  logic [35:0]  dataO;
  logic         busREQO;
  logic         busACKI;
  logic [35:0]  busADDRO;
  logic [35:0]  busDATAO;
  logic [35:0]  busDATAI;
  logic [3:0]   grantO;
  logic         busyO;
  logic         tmoO;

  int checks = 0;
  int errors = 0;

  // {ackO, grantO, busREQO, busyO, tmoO}
  logic [10:0] st;
  assign st = {ackO, grantO, busREQO, busyO, tmoO};

  always #5 clk = ~clk;

  bus_arbiter #(
    .NREQ  (4),
    .TMOCNT(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .reqI    (reqI),
    .addrI   (addrI),
    .dataI   (dataI),
    .ackO    (ackO),
    .dataO   (dataO),
    .busREQO (busREQO),
    .busACKI (busACKI),
    .busADDRO(busADDRO),
    .busDATAO(busDATAO),
    .busDATAI(busDATAI),
    .grantO  (grantO),
    .busyO   (busyO),
    .tmoO    (tmoO)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    reqI     = 4'b1111;
    busACKI  = 1'b0;
    busDATAI = 36'o777777777777;
    for (int i = 0; i < 4; i++) begin
      addrI[36*i +: 36] = 36'(i + 1);
      dataI[36*i +: 36] = 36'(i + 100);
    end
    tick();
    tick();
    checks++;
    if (st !== 11'b0) begin
      errors++; $display("FAIL reset status: got %b want %b", st, 11'b0);
    end
    checks++;
    if ({busADDRO, busDATAO, dataO} !== 108'b0) begin
      errors++; $display("FAIL reset data: got %h %h %h want 0", busADDRO, busDATAO, dataO);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (st !== {4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset release grant: got %b want %b", st,
                         {4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0});
    end
    reqI    = 4'b0000;
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    tick();
    checks++;
    if (st !== 11'b0) begin
      errors++; $display("FAIL reset txn idle: got %b want %b", st, 11'b0);
    end
  endtask

  task automatic test_single_read();
    reqI = 4'b0100;
    addrI[72 +: 36] = 36'o040000001000;
    dataI[72 +: 36] = 36'o000011112222;
    tick();
    checks++;
    if (st !== {4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single grant: got %b want %b", st, {4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0});
    end
    checks++;
    if ({busADDRO, busDATAO} !== {36'o040000001000, 36'o000011112222}) begin
      errors++; $display("FAIL single latch: got %o %o want %o %o", busADDRO, busDATAO,
                         36'o040000001000, 36'o000011112222);
    end
    tick();
    checks++;
    if (st !== {4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single wait: got %b want %b", st, {4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0});
    end
    busACKI  = 1'b1;
    busDATAI = 36'o123456701234;
    tick();
    busACKI  = 1'b0;
    busDATAI = 36'o0;
    checks++;
    if (st !== {4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single ack: got %b want %b", st, {4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0});
    end
    checks++;
    if (dataO !== 36'o123456701234) begin
      errors++; $display("FAIL single data: got %o want %o", dataO, 36'o123456701234);
    end
    reqI = 4'b0000;
    tick();
    checks++;
    if (st !== 11'b0) begin
      errors++; $display("FAIL single release: got %b want %b", st, 11'b0);
    end
  endtask

  task automatic test_priority();
    reqI = 4'b1010;
    addrI[108 +: 36] = 36'o300000000003;
    tick();
    checks++;
    if (grantO !== 4'b0010) begin
      errors++; $display("FAIL prio first grant: got %b want %b", grantO, 4'b0010);
    end
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    checks++;
    if (ackO !== 4'b0010) begin
      errors++; $display("FAIL prio first ack: got %b want %b", ackO, 4'b0010);
    end
    reqI = 4'b1000;
    tick();
    checks++;
    if (st !== 11'b0) begin
      errors++; $display("FAIL prio gap idle: got %b want %b", st, 11'b0);
    end
    tick();
    checks++;
    if (st !== {4'b0000, 4'b1000, 1'b1, 1'b1, 1'b0} || busADDRO !== 36'o300000000003) begin
      errors++; $display("FAIL prio second grant: got %b %o want %b %o", st, busADDRO,
                         {4'b0000, 4'b1000, 1'b1, 1'b1, 1'b0}, 36'o300000000003);
    end
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    reqI    = 4'b0000;
    checks++;
    if (ackO !== 4'b1000) begin
      errors++; $display("FAIL prio second ack: got %b want %b", ackO, 4'b1000);
    end
    tick();
  endtask

  task automatic test_drop_late_ack();
    int bad = 0;
    reqI = 4'b0001;
    tick();
    tick();
    reqI = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      if (st !== {4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0}) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL drop wait hold: got %0d bad cycles want 0", bad);
    end
    busACKI  = 1'b1;
    busDATAI = 36'o555444333222;
    tick();
    busACKI  = 1'b0;
    checks++;
    if (ackO !== 4'b0001 || dataO !== 36'o555444333222) begin
      errors++; $display("FAIL drop late ack: got %b %o want %b %o", ackO, dataO, 4'b0001,
                         36'o555444333222);
    end
    tick();
    busACKI = 1'b1;
    tick();
    tick();
    busACKI = 1'b0;
    checks++;
    if (st !== 11'b0) begin
      errors++; $display("FAIL stray ack idle: got %b want %b", st, 11'b0);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    reqI = 4'b0100;
    tick();
`ifdef BUSARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      if (ackO !== 4'b0000 || tmoO !== 1'b0 || busyO !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || ackO !== 4'b0000) begin
      errors++; $display("FAIL tmo early: got %0d bad cycles ack %b want 0 0000", bad, ackO);
    end
    tick();
    checks++;
    if (st !== {4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1} || dataO !== 36'o0) begin
      errors++; $display("FAIL tmo pulse: got %b %o want %b 0", st, dataO,
                         {4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1});
    end
    reqI = 4'b0000;
    tick();
`else
    for (int i = 0; i < 40; i++) begin
      if (ackO !== 4'b0000 || tmoO !== 1'b0 || busyO !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL no-tmo hold: got %0d bad cycles want 0", bad);
    end
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    reqI    = 4'b0000;
    checks++;
    if (ackO !== 4'b0100 || tmoO !== 1'b0) begin
      errors++; $display("FAIL no-tmo ack: got %b %b want 0100 0", ackO, tmoO);
    end
    tick();
`endif
    checks++;
    if (st !== 11'b0) begin
      errors++; $display("FAIL tmo release: got %b want %b", st, 11'b0);
    end
  endtask

  task automatic test_reset_mid_wait();
    reqI = 4'b0010;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (st !== 11'b0) begin
      errors++; $display("FAIL midwait reset: got %b want %b", st, 11'b0);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (st !== {4'b0000, 4'b0010, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL midwait regrant: got %b want %b", st, {4'b0000, 4'b0010, 1'b1, 1'b1, 1'b0});
    end
    busACKI  = 1'b1;
    busDATAI = 36'o010203040506;
    tick();
    busACKI  = 1'b0;
    reqI     = 4'b0000;
    checks++;
    if (ackO !== 4'b0010 || dataO !== 36'o010203040506) begin
      errors++; $display("FAIL midwait ack: got %b %o want 0010 %o", ackO, dataO, 36'o010203040506);
    end
    tick();
    checks++;
    if (st !== 11'b0) begin
      errors++; $display("FAIL midwait idle: got %b want %b", st, 11'b0);
    end
  endtask

  initial begin
    addrI = '0;
    dataI = '0;
    test_reset();
    test_single_read();
    test_priority();
    test_drop_late_ack();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
